gs_div_seq: RTL and testbench

- Self-sequenced, parametrised Goldschmidt divider: q ≈ x/d.
- Successor to the 8-bit externally-steered divide-convergence datapath.
- Adds:
  - parametric width and iteration count;
  - on-chip initial-reciprocal table;
  - internal FSM;
  - start/busy/done handshake;
  - operand error flag.
- One shared W×W multiplier feeds an RNE rounder and a 2's-complement unit, used as in the existing datapath.

---
 rtl/gs_div_seq.sv | 150 +++++++++++++++
 tb/tb_gs_div_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gs_div_seq.sv
// Goldschmidt divider q ~= x/d on 1.(W-1) fixed-point operands.
// A single W x W multiplier is time-shared by a small FSM: seed D and N with
// a table reciprocal, then alternate N*R and D*R steps until ITER N steps
// have been taken. Every product is rounded to nearest-even back to 1.(W-1).
module gs_div_seq #(
  parameter int W     = 8,
  parameter int ITER  = 3,
  parameter int TBITS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] d,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] q
);

  localparam int T  = 2 ** TBITS;
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [2:0] {IDLE, INITD, INITN, ITN, ITD, FIN} state_t;

  state_t          state;
  logic [W-1:0]    xr, dr;        // latched operands
  logic [W-1:0]    n, dd, r;      // numerator, denominator, correction 2-D
  logic [CW-1:0]   cnt;           // N steps taken so far
  logic [W-1:0]    ma, mb;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    rp;            // rounded product
  logic [W-1:0]    r0;
  logic [TBITS-1:0] idx;

  // Seed reciprocal for the interval whose midpoint is (2T+2i+1)/(2T).
  function automatic logic [W-1:0] r0_calc(input int i);
    longint num, den;
    den = longint'(2 * T + 2 * i + 1);
    num = (longint'(1) << (W + 1)) * longint'(T) + den;
    return W'(num / (2 * den));
  endfunction

  // Round a 2.(2W-2) product to 1.(W-1), ties to even, clamping on overflow.
  function automatic logic [W-1:0] rne(input logic [2*W-1:0] p);
    logic [W-1:0] keep;
    logic         guard, sticky;
    logic [W:0]   sum;
    keep   = p[2*W-2:W-1];
    guard  = p[W-2];
    sticky = |p[W-3:0];
    sum    = {1'b0, keep} + {{W{1'b0}}, guard & (sticky | keep[0])};
    if (p[2*W-1] || sum[W]) return '1;
    return sum[W-1:0];
  endfunction

  // 2 - v in 1.(W-1) is the W-bit two's complement of v.
  function automatic logic [W-1:0] twos(input logic [W-1:0] v);
    return (~v) + {{(W-1){1'b0}}, 1'b1};
  endfunction

  logic [W-1:0] r0_tab [T];
  for (genvar g = 0; g < T; g++) begin : g_tab
    assign r0_tab[g] = r0_calc(g);
  end

  assign idx = dr[W-2 -: TBITS];
  assign r0  = r0_tab[idx];

  // Steer the shared multiplier according to the step being performed.
  always_comb begin
    ma = dd;
    mb = r;
    case (state)
      INITD:   begin ma = dr; mb = r0; end
      INITN:   begin ma = xr; mb = r0; end
      ITN:     begin ma = n;  mb = r;  end
      default: ;
    endcase
  end

  assign prod = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
  assign rp   = rne(prod);

  // Sequencer: operand capture, convergence steps and result/flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      q     <= '0;
      xr    <= '0;
      dr    <= '0;
      n     <= '0;
      dd    <= '0;
      r     <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xr    <= x;
            dr    <= d;
            busy  <= 1'b1;
            err   <= 1'b0;
            state <= (!x[W-1] || !d[W-1]) ? FIN : INITD;
          end
        end
        INITD: begin
          dd    <= rp;
          r     <= twos(rp);
          state <= INITN;
        end
        INITN: begin
          n     <= rp;
          cnt   <= CW'(1);
          state <= ITN;
        end
        ITN: begin
          n <= rp;
          if (cnt == CW'(ITER)) begin
            q     <= rp;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= ITD;
          end
        end
        ITD: begin
          dd    <= rp;
          r     <= twos(rp);
          cnt   <= cnt + CW'(1);
          state <= ITN;
        end
        FIN: begin
          q     <= '1;
          err   <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gs_div_seq.sv
// Directed and randomised checks for gs_div_seq (W=8, ITER=3, TBITS=3).
module tb_gs_div_seq;

  localparam int W     = 8;
  localparam int ITER  = 3;
  localparam int TBITS = 3;
  localparam int T     = 2 ** TBITS;
  localparam int ONE   = 2 ** (W - 1);
  localparam int HALF  = 2 ** (W - 2);
  localparam int FULL  = 2 ** W;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] x, d;
  logic         busy, done, err;
  logic [W-1:0] q;

  int checks   = 0;
  int failures = 0;

  gs_div_seq #(.W(W), .ITER(ITER), .TBITS(TBITS)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .d(d),
    .busy(busy), .done(done), .err(err), .q(q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         e;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: integer-arithmetic rounding of a 2.(2W-2) product.
  function automatic int rne_m(input int p);
    int keep, rem, v;
    keep = p / ONE;
    rem  = p % ONE;
    v    = keep + (((rem > HALF) || (rem == HALF && (keep % 2) == 1)) ? 1 : 0);
    if (p >= FULL * ONE || v >= FULL) return FULL - 1;
    return v;
  endfunction

  function automatic int model_q(input int xi, input int di);
    int i, den, r0, dv, rv, nv;
    if (xi < ONE || di < ONE) return FULL - 1;
    i   = (di / (ONE / T)) % T;
    den = 2 * T + 2 * i + 1;
    r0  = ((2 ** (W + 1)) * T + den) / (2 * den);
    dv  = rne_m(di * r0);
    rv  = (FULL - dv) % FULL;
    nv  = rne_m(xi * r0);
    for (int it = 1; it <= ITER; it++) begin
      nv = rne_m(nv * rv);
      if (it < ITER) begin
        dv = rne_m(dv * rv);
        rv = (FULL - dv) % FULL;
      end
    end
    return nv;
  endfunction

  // Wait up to a bounded number of edges for done; 0 means it never came.
  task automatic wait_done(output int lat, output int bad_busy);
    lat = 0;
    bad_busy = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      if (done) lat = k;
      else if (!busy) bad_busy++;
    end
  endtask

  task automatic run_div(input string name, input logic [W-1:0] xi, input logic [W-1:0] di,
                         input logic [W-1:0] eq, input logic ee, input int el);
    int lat, bb;
    x = xi; d = di; start = 1'b1;
    tick();
    start = 1'b0;
    x = ~xi; d = ~di;
    chk({name, "_busy_acc"}, int'(busy), 1);
    wait_done(lat, bb);
    chk({name, "_lat"}, lat, el);
    chk({name, "_q"}, int'(q), int'(eq));
    chk({name, "_err"}, int'(err), int'(ee));
    chk({name, "_busy_gap"}, bb, 0);
    chk({name, "_busy_end"}, int'(busy), 0);
    tick();
    chk({name, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    vec_t tbl [8];
    int ndone, e1, e2, lat, bb, mq, xi, di;
    real ideal, diff;

    tbl[0] = '{8'h80, 8'h80, 8'h80, 1'b0, 7};
    tbl[1] = '{8'hC0, 8'h80, 8'hBF, 1'b0, 7};
    tbl[2] = '{8'hFF, 8'h80, 8'hFE, 1'b0, 7};
    tbl[3] = '{8'h80, 8'hFF, 8'h40, 1'b0, 7};
    tbl[4] = '{8'hA0, 8'hC0, 8'h6A, 1'b0, 7};
    tbl[5] = '{8'hE0, 8'h90, 8'hC6, 1'b0, 7};
    tbl[6] = '{8'h80, 8'h40, 8'hFF, 1'b1, 1};
    tbl[7] = '{8'h40, 8'h80, 8'hFF, 1'b1, 1};

    reset = 1'b1; start = 1'b0; x = '0; d = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err",  int'(err),  0);
    chk("rst_q",    int'(q),    0);

    for (int i = 0; i < 8; i++)
      run_div($sformatf("vec%0d", i), tbl[i].x, tbl[i].d, tbl[i].q, tbl[i].e, tbl[i].lat);

    // A valid start after an error clears err at acceptance.
    run_div("err_set", 8'h80, 8'h40, 8'hFF, 1'b1, 1);
    x = 8'h80; d = 8'h80; start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_clear", int'(err), 0);
    wait_done(lat, bb);
    chk("err_clear_lat", lat, 7);
    chk("err_clear_q", int'(q), 8'h80);
    tick();

    // Reset at edge 4 aborts with no done afterwards.
    x = 8'hC0; d = 8'h80; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_q", int'(q), 0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_div("after_abort", 8'hC0, 8'h80, 8'hBF, 1'b0, 7);

    // Starts pulsed at edges 2 and 5 while busy are ignored.
    x = 8'h80; d = 8'h80; start = 1'b1;
    tick();
    x = 8'hC0; d = 8'h90;
    ndone = 0; e1 = 0;
    for (int e = 1; e <= 14; e++) begin
      start = (e == 2 || e == 5);
      tick();
      if (done) begin ndone++; e1 = e; end
    end
    start = 1'b0;
    chk("ignore_ndone", ndone, 1);
    chk("ignore_edge", e1, 7);
    chk("ignore_q", int'(q), 8'h80);

    // Start held through done: second division accepted at edge 8.
    x = 8'hC0; d = 8'h80; start = 1'b1;
    ndone = 0; e1 = 0; e2 = 0;
    for (int e = 0; e <= 17; e++) begin
      if (e == 9) start = 1'b0;
      tick();
      if (done) begin
        ndone++;
        if (e1 == 0) e1 = e; else e2 = e;
      end
      if (e == 8) chk("b2b_busy_e8", int'(busy), 1);
    end
    chk("b2b_ndone", ndone, 2);
    chk("b2b_first", e1, 7);
    chk("b2b_second", e2, 15);
    chk("b2b_q", int'(q), 8'hBF);
    chk("b2b_err", int'(err), 0);

    // Random normalised operands against the reference sequence.
    for (int n = 0; n < 2000; n++) begin
      xi = int'($urandom_range(FULL - 1, ONE));
      di = int'($urandom_range(FULL - 1, ONE));
      mq = model_q(xi, di);
      run_div("rand", W'(xi), W'(di), W'(mq), 1'b0, 7);
      ideal = real'(xi) * real'(ONE) / real'(di);
      diff  = real'(int'(q)) - ideal;
      if (diff < 0.0) diff = -diff;
      chk("rand_ulp", int'(diff <= real'(ITER + 1)), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
